// File: rtl/sys_cmd_pkg.sv
// Shared types and command constants for the UART command controller.
package sys_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OPA,
    OPB,
    FUN
  } cmd_state_e;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

endpackage

// File: rtl/sys_cmd_timer.sv
// Inter-byte idle watchdog for sys_cmd_ctrl; only instantiated when
// SYS_CMD_TIMEOUT_EN is defined.
module sys_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic reload_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT_CYCLES-th idle cycle so the FSM leaves on that edge.
  assign expired_o = active_i && !reload_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i || !active_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// UART command decoder driving register-file and ALU strobes.
// Optional inter-byte timeout enabled by defining SYS_CMD_TIMEOUT_EN.
module sys_cmd_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_SIZE      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  REF_CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_SIZE-1:0]  RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  CMD_BUSY
);

  cmd_state_e            state_q, state_d;
  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic                  rf_wren_q, rf_wren_d;
  logic                  rf_rden_q, rf_rden_d;
  logic [ADDR_SIZE-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;
  logic                  alu_en_q, alu_en_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  clk_gate_q, clk_gate_d;
  logic                  timeout;
  logic                  abort;

`ifdef SYS_CMD_TIMEOUT_EN
  sys_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (REF_CLK),
    .rst_ni   (RST),
    .reload_i (RX_D_VLD),
    .active_i (state_q != IDLE),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign abort = RX_ERR || timeout;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rf_wren_d   = 1'b0;
    rf_rden_d   = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wrdata_d = rf_wrdata_q;
    alu_en_d    = 1'b0;
    alu_fun_d   = alu_fun_q;
    clk_gate_d  = clk_gate_q;

    // Gate drops the cycle after the ALU start pulse; a new CC/DD below re-raises it.
    if (alu_en_q) begin
      clk_gate_d = 1'b0;
    end

    if (abort) begin
      state_d    = IDLE;
      clk_gate_d = 1'b0;
    end else if (RX_D_VLD) begin
      unique case (state_q)
        IDLE: begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR)) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD)) begin
            state_d = RD_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_d    = OPA;
            clk_gate_d = 1'b1;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_d    = FUN;
            clk_gate_d = 1'b1;
          end
        end
        WR_ADDR: begin
          wr_addr_d = RX_P_DATA[ADDR_SIZE-1:0];
          state_d   = WR_DATA;
        end
        WR_DATA: begin
          rf_wren_d   = 1'b1;
          rf_addr_d   = wr_addr_q;
          rf_wrdata_d = RX_P_DATA;
          state_d     = IDLE;
        end
        RD_ADDR: begin
          rf_rden_d = 1'b1;
          rf_addr_d = RX_P_DATA[ADDR_SIZE-1:0];
          state_d   = IDLE;
        end
        OPA: begin
          rf_wren_d   = 1'b1;
          rf_addr_d   = ADDR_SIZE'(OPA_ADDR);
          rf_wrdata_d = RX_P_DATA;
          state_d     = OPB;
        end
        OPB: begin
          rf_wren_d   = 1'b1;
          rf_addr_d   = ADDR_SIZE'(OPB_ADDR);
          rf_wrdata_d = RX_P_DATA;
          state_d     = FUN;
        end
        FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[3:0];
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rf_wren_q   <= 1'b0;
      rf_rden_q   <= 1'b0;
      rf_addr_q   <= '0;
      rf_wrdata_q <= '0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      clk_gate_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rf_wren_q   <= rf_wren_d;
      rf_rden_q   <= rf_rden_d;
      rf_addr_q   <= rf_addr_d;
      rf_wrdata_q <= rf_wrdata_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      clk_gate_q  <= clk_gate_d;
    end
  end

  assign RF_WrEn     = rf_wren_q;
  assign RF_RdEn     = rf_rden_q;
  assign RF_Address  = rf_addr_q;
  assign RF_WrData   = rf_wrdata_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign CMD_BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl; timeout scenario runs when SYS_CMD_TIMEOUT_EN is defined.
module tb_sys_cmd_ctrl;

  logic       REF_CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       RX_ERR = 1'b0;
  logic       RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, CMD_BUSY;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [3:0] ALU_FUN;

  int total = 0;
  int bad = 0;
  int n_wr = 0, n_rd = 0, n_alu = 0, n_multi = 0;

  sys_cmd_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_SIZE(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .REF_CLK    (REF_CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RX_ERR     (RX_ERR),
    .RF_WrEn    (RF_WrEn),
    .RF_RdEn    (RF_RdEn),
    .RF_Address (RF_Address),
    .RF_WrData  (RF_WrData),
    .ALU_EN     (ALU_EN),
    .ALU_FUN    (ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN),
    .CMD_BUSY   (CMD_BUSY)
  );

  always #5 REF_CLK = ~REF_CLK;

  always @(negedge REF_CLK) begin
    if (RF_WrEn) n_wr++;
    if (RF_RdEn) n_rd++;
    if (ALU_EN) n_alu++;
    if ((int'(RF_WrEn) + int'(RF_RdEn) + int'(ALU_EN)) > 1) n_multi++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    n_wr = 0; n_rd = 0; n_alu = 0;
  endtask

  // Byte is accepted on the next rising edge; return 1 ns after it.
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    RX_P_DATA = b; RX_D_VLD = 1'b1; RX_ERR = err;
    @(posedge REF_CLK); #1;
    RX_D_VLD = 1'b0; RX_ERR = 1'b0;
  endtask

  task automatic err_pulse();
    RX_ERR = 1'b1;
    @(posedge REF_CLK); #1;
    RX_ERR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge REF_CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #22;
    total++; if (RF_WrEn !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", RF_WrEn); end
    total++; if (RF_RdEn !== 1'b0) begin bad++; $display("FAIL reset_rden: got %b want 0", RF_RdEn); end
    total++; if ({RF_Address, RF_WrData, ALU_FUN} !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", {RF_Address, RF_WrData, ALU_FUN}); end
    total++; if ({ALU_EN, CLK_GATE_EN, CMD_BUSY} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {ALU_EN, CLK_GATE_EN, CMD_BUSY}); end
    @(negedge REF_CLK); RST = 1'b1;
    idle(1);
  endtask

  task automatic test_rf_write();
    clr();
    send(8'hAA);
    total++; if (CMD_BUSY !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", CMD_BUSY); end
    send(8'h04);
    total++; if (RF_WrEn !== 1'b0) begin bad++; $display("FAIL wr_early: got %b want 0", RF_WrEn); end
    send(8'h3C);
    total++; if (RF_WrEn !== 1'b1) begin bad++; $display("FAIL wr_strobe: got %b want 1", RF_WrEn); end
    total++; if (RF_Address !== 4'h4) begin bad++; $display("FAIL wr_addr: got %h want 4", RF_Address); end
    total++; if (RF_WrData !== 8'h3C) begin bad++; $display("FAIL wr_data: got %h want 3c", RF_WrData); end
    total++; if (CMD_BUSY !== 1'b0) begin bad++; $display("FAIL wr_done_busy: got %b want 0", CMD_BUSY); end
    idle(3);
    total++; if (n_wr !== 1 || n_rd !== 0 || n_alu !== 0) begin bad++; $display("FAIL wr_count: got wr=%0d rd=%0d alu=%0d want 1 0 0", n_wr, n_rd, n_alu); end
    total++; if ({RF_Address, RF_WrData} !== 12'h43C) begin bad++; $display("FAIL wr_hold: got %h want 43c", {RF_Address, RF_WrData}); end
    // upper address bits are dropped
    send(8'hAA); send(8'hF7); send(8'h55);
    total++; if ({RF_WrEn, RF_Address, RF_WrData} !== 13'h1755) begin bad++; $display("FAIL wr_addr_trunc: got %h want 1755", {RF_WrEn, RF_Address, RF_WrData}); end
    idle(1);
  endtask

  task automatic test_rf_read();
    clr();
    send(8'hBB); send(8'h04);
    total++; if (RF_RdEn !== 1'b1) begin bad++; $display("FAIL rd_strobe: got %b want 1", RF_RdEn); end
    total++; if (RF_Address !== 4'h4) begin bad++; $display("FAIL rd_addr: got %h want 4", RF_Address); end
    idle(2);
    total++; if (n_rd !== 1 || n_wr !== 0) begin bad++; $display("FAIL rd_count: got rd=%0d wr=%0d want 1 0", n_rd, n_wr); end
  endtask

  task automatic test_alu_op();
    clr();
    send(8'hCC);
    total++; if (CLK_GATE_EN !== 1'b1) begin bad++; $display("FAIL op_gate_rise: got %b want 1", CLK_GATE_EN); end
    send(8'hF0);
    total++; if ({RF_WrEn, RF_Address, RF_WrData} !== 13'h10F0) begin bad++; $display("FAIL op_a: got %h want 10f0", {RF_WrEn, RF_Address, RF_WrData}); end
    send(8'h0F);
    total++; if ({RF_WrEn, RF_Address, RF_WrData} !== 13'h110F) begin bad++; $display("FAIL op_b: got %h want 110f", {RF_WrEn, RF_Address, RF_WrData}); end
    total++; if (CLK_GATE_EN !== 1'b1) begin bad++; $display("FAIL op_gate_mid: got %b want 1", CLK_GATE_EN); end
    send(8'h00);
    total++; if ({ALU_EN, ALU_FUN, CLK_GATE_EN, RF_WrEn} !== 7'b1000010) begin bad++; $display("FAIL op_fun: got %b want 1000010", {ALU_EN, ALU_FUN, CLK_GATE_EN, RF_WrEn}); end
    idle(1);
    total++; if ({ALU_EN, CLK_GATE_EN} !== 2'b00) begin bad++; $display("FAIL op_gate_fall: got %b want 00", {ALU_EN, CLK_GATE_EN}); end
    total++; if (n_wr !== 2 || n_alu !== 1 || n_rd !== 0) begin bad++; $display("FAIL op_count: got wr=%0d alu=%0d rd=%0d want 2 1 0", n_wr, n_alu, n_rd); end
  endtask

  task automatic test_alu_nop();
    clr();
    send(8'hDD);
    total++; if (CLK_GATE_EN !== 1'b1) begin bad++; $display("FAIL nop_gate: got %b want 1", CLK_GATE_EN); end
    send(8'h01);
    total++; if ({ALU_EN, ALU_FUN} !== 5'b10001) begin bad++; $display("FAIL nop_fun: got %b want 10001", {ALU_EN, ALU_FUN}); end
    idle(1);
    total++; if (CLK_GATE_EN !== 1'b0) begin bad++; $display("FAIL nop_gate_fall: got %b want 0", CLK_GATE_EN); end
    total++; if (n_alu !== 1 || n_wr !== 0 || n_rd !== 0) begin bad++; $display("FAIL nop_count: got alu=%0d wr=%0d rd=%0d want 1 0 0", n_alu, n_wr, n_rd); end
    total++; if (ALU_FUN !== 4'h1) begin bad++; $display("FAIL nop_fun_hold: got %h want 1", ALU_FUN); end
  endtask

  task automatic test_ignore();
    clr();
    send(8'h55);
    total++; if (CMD_BUSY !== 1'b0) begin bad++; $display("FAIL ign_busy: got %b want 0", CMD_BUSY); end
    idle(2);
    total++; if (n_wr + n_rd + n_alu !== 0 || CLK_GATE_EN !== 1'b0) begin bad++; $display("FAIL ign_strobes: got %0d gate=%b want 0 0", n_wr + n_rd + n_alu, CLK_GATE_EN); end
  endtask

  task automatic test_rx_err();
    clr();
    send(8'hAA); send(8'h04);
    err_pulse();
    total++; if (CMD_BUSY !== 1'b0) begin bad++; $display("FAIL err_idle: got %b want 0", CMD_BUSY); end
    send(8'h3C);
    idle(1);
    total++; if (n_wr !== 0) begin bad++; $display("FAIL err_no_wr: got %0d want 0", n_wr); end
    send(8'hAA); send(8'h04); send(8'h3C, 1'b1);
    total++; if ({RF_WrEn, CMD_BUSY} !== 2'b00) begin bad++; $display("FAIL err_coinc: got %b want 00", {RF_WrEn, CMD_BUSY}); end
    send(8'hCC);
    err_pulse();
    total++; if ({CLK_GATE_EN, CMD_BUSY} !== 2'b00) begin bad++; $display("FAIL err_gate: got %b want 00", {CLK_GATE_EN, CMD_BUSY}); end
    send(8'hBB); send(8'h02);
    total++; if ({RF_RdEn, RF_Address} !== 5'h12) begin bad++; $display("FAIL err_recover: got %h want 12", {RF_RdEn, RF_Address}); end
    idle(1);
    total++; if (n_wr !== 0 || n_rd !== 1 || n_alu !== 0) begin bad++; $display("FAIL err_count: got wr=%0d rd=%0d alu=%0d want 0 1 0", n_wr, n_rd, n_alu); end
  endtask

  task automatic test_timeout();
    clr();
    send(8'hAA);
`ifdef SYS_CMD_TIMEOUT_EN
    idle(15);
    total++; if (CMD_BUSY !== 1'b1) begin bad++; $display("FAIL tmo_before: got %b want 1", CMD_BUSY); end
    idle(1);
    total++; if (CMD_BUSY !== 1'b0) begin bad++; $display("FAIL tmo_expire: got %b want 0", CMD_BUSY); end
    send(8'h04); send(8'h3C);
    total++; if (RF_WrEn !== 1'b0) begin bad++; $display("FAIL tmo_no_wr: got %b want 0", RF_WrEn); end
`else
    idle(40);
    total++; if (CMD_BUSY !== 1'b1) begin bad++; $display("FAIL wait_forever: got %b want 1", CMD_BUSY); end
    send(8'h04); send(8'h3C);
    total++; if ({RF_WrEn, RF_Address, RF_WrData} !== 13'h143C) begin bad++; $display("FAIL wait_late_wr: got %h want 143c", {RF_WrEn, RF_Address, RF_WrData}); end
`endif
    idle(1);
  endtask

  task automatic test_reset_mid();
    clr();
    send(8'hCC); send(8'hF0);
    #2 RST = 1'b0;
    #1;
    total++; if ({RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, CMD_BUSY} !== 5'b0) begin bad++; $display("FAIL rstmid_ctrl: got %b want 00000", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, CMD_BUSY}); end
    total++; if ({RF_Address, RF_WrData, ALU_FUN} !== 16'h0) begin bad++; $display("FAIL rstmid_data: got %h want 0000", {RF_Address, RF_WrData, ALU_FUN}); end
    @(negedge REF_CLK); RST = 1'b1;
    clr();
    send(8'h0F); send(8'h00);
    idle(2);
    total++; if (n_wr + n_rd + n_alu !== 0 || CMD_BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_discard: got %0d busy=%b want 0 0", n_wr + n_rd + n_alu, CMD_BUSY); end
  endtask

  task automatic test_back_to_back();
    clr();
    send(8'hAA); send(8'h01); send(8'h11);
    total++; if ({RF_WrEn, RF_Address, RF_WrData} !== 13'h1111) begin bad++; $display("FAIL b2b_wr: got %h want 1111", {RF_WrEn, RF_Address, RF_WrData}); end
    send(8'hBB);
    total++; if (RF_WrEn !== 1'b0) begin bad++; $display("FAIL b2b_wr_drop: got %b want 0", RF_WrEn); end
    send(8'h09);
    total++; if ({RF_RdEn, RF_Address} !== 5'h19) begin bad++; $display("FAIL b2b_rd: got %h want 19", {RF_RdEn, RF_Address}); end
    send(8'hDD); send(8'h07); send(8'hCC);
    total++; if ({ALU_EN, CLK_GATE_EN} !== 2'b01) begin bad++; $display("FAIL b2b_regate: got %b want 01", {ALU_EN, CLK_GATE_EN}); end
    err_pulse();
    idle(1);
    total++; if (n_wr !== 1 || n_rd !== 1 || n_alu !== 1 || n_multi !== 0) begin bad++; $display("FAIL b2b_count: got wr=%0d rd=%0d alu=%0d multi=%0d want 1 1 1 0", n_wr, n_rd, n_alu, n_multi); end
  endtask

  initial begin
    test_reset();
    test_rf_write();
    test_rf_read();
    test_alu_op();
    test_alu_nop();
    test_ignore();
    test_rx_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
